// File: rtl/vid_timing_patgen.sv
// Video raster timing (DE/HS/VS) and test-pattern generator, YCbCr 4:2:2 luma patterns.
// Latency 2 cycles from counters to outputs; no backpressure, free-running at the pixel rate.
module vid_timing_patgen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int CNT_W    = 12,
    parameter int BOX_SIZE = 128,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int FCNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic [3:0]        mode_i,
    input  logic [CNT_W-1:0]  box_x_i,
    input  logic [CNT_W-1:0]  box_y_i,
    input  logic [7:0]        solid_y_i,
    output logic              running_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic [15:0]       data_o,
    output logic              sof_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W:0]   BOX_W  = (CNT_W+1)'(BOX_SIZE);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               frame_start;

    logic [3:0]         mode_q;
    logic [CNT_W-1:0]   box_x_q, box_y_q;
    logic [7:0]         solid_y_q;

    logic               s1_de_q, s1_hs_q, s1_vs_q, s1_sof_q;
    logic [15:0]        s1_dat_q;
    logic               s1_de_d, s1_hs_d, s1_vs_d, s1_sof_d;
    logic [15:0]        s1_dat_d;

    logic               de_q, hs_q, vs_q, sof_q;
    logic [15:0]        dat_q;

    // Counters and run control
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en_i) begin
                    state_d     = ST_RUN;
                    frame_start = 1'b1;
                end
            end
            default: begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
                if (hcnt_q == H_LAST && vcnt_q == V_LAST) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (en_i) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Shadows load on the edge that enters (0,0), so pixel (0,0) already sees the new settings.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q    <= '0;
            box_x_q   <= '0;
            box_y_q   <= '0;
            solid_y_q <= '0;
        end else if (frame_start) begin
            mode_q    <= mode_i;
            box_x_q   <= box_x_i;
            box_y_q   <= box_y_i;
            solid_y_q <= solid_y_i;
        end
    end

    // Decode and pattern stage; box end computed one bit wider so a box near the edge never wraps.
    logic       act, hs_act, vs_act, in_box;
    logic [2:0] bar;
    logic [7:0] luma;
    logic [CNT_W:0] box_x_end, box_y_end;

    always_comb begin
        act       = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_act    = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vs_act    = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        box_x_end = {1'b0, box_x_q} + BOX_W;
        box_y_end = {1'b0, box_y_q} + BOX_W;
        in_box    = (hcnt_q >= box_x_q) && ({1'b0, hcnt_q} < box_x_end) &&
                    (vcnt_q >= box_y_q) && ({1'b0, vcnt_q} < box_y_end);

        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (32'(hcnt_q) >= (k * H_ACTIVE + 7) / 8) begin
                bar = 3'(k);
            end
        end

        luma = 8'd16;
        case (mode_q)
            4'd0:  luma = hcnt_q[7:0];
            4'd1:  luma = vcnt_q[7:0];
            4'd2:  luma = hcnt_q[8:1];
            4'd3:  luma = vcnt_q[8:1];
            4'd4:  luma = hcnt_q[9:2];
            4'd5:  luma = vcnt_q[9:2];
            4'd6:  luma = hcnt_q[10:3];
            4'd7:  luma = vcnt_q[10:3];
            4'd8:  luma = in_box ? vcnt_q[7:0] : hcnt_q[7:0];
            4'd9:  luma = in_box ? frame_cnt_q[7:0] : hcnt_q[7:0];
            4'd10: begin
                case (bar)
                    3'd0:    luma = 8'd235;
                    3'd1:    luma = 8'd210;
                    3'd2:    luma = 8'd170;
                    3'd3:    luma = 8'd145;
                    3'd4:    luma = 8'd106;
                    3'd5:    luma = 8'd81;
                    3'd6:    luma = 8'd41;
                    default: luma = 8'd16;
                endcase
            end
            4'd11: luma = solid_y_q;
            4'd12: luma = (hcnt_q[5] ^ vcnt_q[5]) ? 8'd235 : 8'd16;
            default: luma = 8'd16;
        endcase

        s1_de_d  = 1'b0;
        s1_hs_d  = !HS_POL;
        s1_vs_d  = !VS_POL;
        s1_sof_d = 1'b0;
        s1_dat_d = 16'h0000;
        if (state_q == ST_RUN) begin
            s1_de_d  = act;
            s1_hs_d  = hs_act ? HS_POL : !HS_POL;
            s1_vs_d  = vs_act ? VS_POL : !VS_POL;
            s1_sof_d = (hcnt_q == '0) && (vcnt_q == '0);
            s1_dat_d = act ? {8'h80, luma} : 16'h8010;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_de_q  <= 1'b0;
            s1_hs_q  <= !HS_POL;
            s1_vs_q  <= !VS_POL;
            s1_sof_q <= 1'b0;
            s1_dat_q <= 16'h0000;
        end else begin
            s1_de_q  <= s1_de_d;
            s1_hs_q  <= s1_hs_d;
            s1_vs_q  <= s1_vs_d;
            s1_sof_q <= s1_sof_d;
            s1_dat_q <= s1_dat_d;
        end
    end

    // Output register stage, kept free of logic so it packs into the IOBs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            de_q  <= 1'b0;
            hs_q  <= !HS_POL;
            vs_q  <= !VS_POL;
            sof_q <= 1'b0;
            dat_q <= 16'h0000;
        end else begin
            de_q  <= s1_de_q;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
            sof_q <= s1_sof_q;
            dat_q <= s1_dat_q;
        end
    end

    assign running_o   = (state_q == ST_RUN);
    assign frame_cnt_o = frame_cnt_q;
    assign de_o        = de_q;
    assign hs_o        = hs_q;
    assign vs_o        = vs_q;
    assign sof_o       = sof_q;
    assign data_o      = dat_q;

endmodule

// File: tb/tb_vid_timing_patgen.sv
// Randomized bench for vid_timing_patgen on a 14x7 raster, against a linear-pixel-index reference model.
module tb_vid_timing_patgen;

    localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int BOX = 2;
    localparam logic [19:0] IDLE = 20'h0_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  mode = 4'd0;
    logic [11:0] box_x = 12'd0;
    logic [11:0] box_y = 12'd0;
    logic [7:0]  solid_y = 8'd0;
    logic        running, de, hs, vs, sof;
    logic [15:0] frame_cnt, data;

    vid_timing_patgen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CNT_W(12), .BOX_SIZE(BOX), .HS_POL(1'b1), .VS_POL(1'b1), .FCNT_W(16)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode),
        .box_x_i(box_x), .box_y_i(box_y), .solid_y_i(solid_y),
        .running_o(running), .frame_cnt_o(frame_cnt),
        .de_o(de), .hs_o(hs), .vs_o(vs), .data_o(data), .sof_o(sof)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: run flag, linear pixel index in the frame, frame count, per-frame settings.
    bit m_run = 0;
    int m_p = 0;
    int m_fcnt = 0;
    int sh_mode = 0, sh_bx = 0, sh_by = 0, sh_sy = 0;
    logic [19:0] vq[$];
    int bars[8] = '{235, 210, 170, 145, 106, 81, 41, 16};

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {de,hs,vs,sof,data} for the current reference state.
    function automatic logic [19:0] ref_pix();
        int h, v, l;
        bit act, hsa, vsa, inb;
        logic [15:0] d;
        if (!m_run) return IDLE;
        h   = m_p % HT;
        v   = m_p / HT;
        act = (h < HA) && (v < VA);
        hsa = (h >= HA + HFP) && (h < HA + HFP + HSY);
        vsa = (v >= VA + VFP) && (v < VA + VFP + VSY);
        inb = (h >= sh_bx) && (h < sh_bx + BOX) && (v >= sh_by) && (v < sh_by + BOX);
        if (sh_mode < 8)       l = (((sh_mode % 2) != 0 ? v : h) >> (sh_mode / 2)) % 256;
        else if (sh_mode == 8) l = inb ? v % 256 : h % 256;
        else if (sh_mode == 9) l = inb ? m_fcnt % 256 : h % 256;
        else if (sh_mode == 10) l = bars[(h * 8) / HA];
        else if (sh_mode == 11) l = sh_sy;
        else if (sh_mode == 12) l = ((((h / 32) + (v / 32)) % 2) != 0) ? 235 : 16;
        else l = 16;
        d = act ? (16'h8000 | 16'(l)) : 16'h8010;
        return {act, hsa, vsa, (m_p == 0), d};
    endfunction

    task automatic latch_settings();
        sh_mode = int'(mode);
        sh_bx   = int'(box_x);
        sh_by   = int'(box_y);
        sh_sy   = int'(solid_y);
    endtask

    task automatic model_reset();
        m_run = 0; m_p = 0; m_fcnt = 0;
        sh_mode = 0; sh_bx = 0; sh_by = 0; sh_sy = 0;
        vq.delete();
        vq.push_back(IDLE);
    endtask

    // One clock: advance the reference with the driven inputs, then compare at the falling edge.
    task automatic step();
        logic [19:0] e;
        vq.push_back(ref_pix());
        if (!rstn) begin
            m_run = 0; m_p = 0; m_fcnt = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1;
                m_p = 0;
                latch_settings();
            end
        end else if (m_p == FT - 1) begin
            m_p = 0;
            m_fcnt = (m_fcnt + 1) % 65536;
            if (en) latch_settings();
            else m_run = 0;
        end else begin
            m_p++;
        end
        @(negedge clk);
        e = vq.pop_front();
        chk("ctl", {47'd0, running, frame_cnt}, {47'd0, m_run, 16'(m_fcnt)});
        chk("vid", {44'd0, de, hs, vs, sof, data}, {44'd0, e});
    endtask

    task automatic chk_reset_vals();
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
        chk("rst_de", 64'(de), 64'd0);
        chk("rst_hs", 64'(hs), 64'd0);
        chk("rst_vs", 64'(vs), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_sof", 64'(sof), 64'd0);
    endtask

    task automatic run_to_pixel(int p);
        int n = 0;
        while (!(m_run && m_p == p) && n < 4 * FT) begin
            step();
            n++;
        end
        chk("reach_pixel", 64'(m_run && m_p == p), 64'd1);
    endtask

    initial begin
        int n, stop_fcnt;
        int bx_pool[6] = '{0, 1, 5, 7, 4094, 4095};

        model_reset();
        #1;
        chk_reset_vals();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            mode = 4'($urandom_range(0, 15));
            step();
        end

        // Startup latency and frame period in mode 0.
        mode = 4'd0;
        en = 1'b1;
        step();
        chk("sof_c1", 64'(sof), 64'd0);
        step();
        chk("sof_c2", 64'(sof), 64'd0);
        step();
        chk("sof_first", 64'(sof), 64'd1);
        chk("first_dat", 64'(data), 64'h8000);
        n = 0;
        do begin
            step();
            n++;
        end while (!sof && n < 200);
        chk("period", 64'(n), 64'd98);

        // Mid-frame settings change takes effect only at the next frame.
        run_to_pixel(HT + 3);
        mode = 4'd11;
        solid_y = 8'h55;
        for (int i = 0; i < 2 * FT; i++) step();

        // Frame-synchronous stop, drain and restart.
        run_to_pixel(2 * HT + 5);
        stop_fcnt = m_fcnt + 1;
        en = 1'b0;
        mode = 4'd0;
        n = 0;
        while (running && n < 2 * FT) begin
            step();
            n++;
        end
        chk("stop_fcnt", 64'(frame_cnt), 64'(stop_fcnt));
        for (int i = 0; i < 20; i++) step();
        en = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!sof && n < 50);
        chk("restart_sof", 64'(sof), 64'd1);
        chk("restart_dat", 64'(data), 64'h8000);
        chk("restart_fcnt", 64'(frame_cnt), 64'(stop_fcnt));

        // Colour bars, then box overlay at (1,1).
        mode = 4'd10;
        for (int i = 0; i < 2 * FT; i++) step();
        mode = 4'd8;
        box_x = 12'd1;
        box_y = 12'd1;
        for (int i = 0; i < 2 * FT; i++) step();

        // Random settings and enable toggling.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) box_x = 12'(bx_pool[$urandom_range(0, 5)]);
            if ($urandom_range(0, 59) == 0) box_y = 12'($urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? 4088 : 0));
            if ($urandom_range(0, 59) == 0) solid_y = 8'($urandom);
            if ($urandom_range(0, 249) == 0) en = ~en;
            step();
        end

        // Asynchronous reset mid-line.
        en = 1'b1;
        run_to_pixel(2 * HT + 4);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals();
        model_reset();
        for (int i = 0; i < 3; i++) step();
        rstn = 1'b1;
        for (int i = 0; i < 3 * FT; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
